// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display blocks: hex font, idle levels, digit index type.
package seg7_pkg;

  localparam int IDX_W = 2;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] CTRL_OFF = 4'hF;

  // gfedcba, active-low, indexed by nibble value 0..F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [IDX_W-1:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/load request and multiplexed display outputs of the scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [7:0]  display;
  logic [3:0]  ctrl;
  logic        frame_tick;

  modport master (
    output value, load, dp_in,
    input  display, ctrl, frame_tick
  );

  modport slave (
    input  value, load, dp_in,
    output display, ctrl, frame_tick
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low gfedcba segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = HEX_FONT[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with frame-aligned double buffering,
// inter-slot guard blanking and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int                CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  logic [15:0]      r_act_val;
  logic [3:0]       r_act_dp;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  logic             r_pend_vld;
  logic [7:0]       r_display;
  logic [3:0]       r_ctrl;
  logic             r_frame_tick;

  logic             w_wrap;
  logic             w_frame;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic             w_blank;

  // Digit i>0 is dark when it and every more-significant nibble are zero and no dp is requested.
  function automatic logic lz_blank(input logic [15:0] val, input logic [3:0] dp,
                                    input digit_idx_t idx);
    logic b;
    case (idx)
      2'd1:    b = (val[15:4]  == 12'h000) && !dp[1];
      2'd2:    b = (val[15:8]  == 8'h00)   && !dp[2];
      2'd3:    b = (val[15:12] == 4'h0)    && !dp[3];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign w_wrap  = (r_cnt == CNT_MAX);
  assign w_frame = w_wrap && (r_idx == digit_idx_t'(3));
  assign w_nib   = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_blank = (BLANK_LZ != 0) && lz_blank(r_act_val, r_act_dp, r_idx);

  seg7_hex_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load landing on the boundary bypasses pending so it is not delayed a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_frame && bus.load) begin
      r_act_val  <= bus.value;
      r_act_dp   <= bus.dp_in;
      r_pend_vld <= 1'b0;
    end else if (w_frame && r_pend_vld) begin
      r_act_val  <= r_pend_val;
      r_act_dp   <= r_pend_dp;
      r_pend_vld <= 1'b0;
    end else if (bus.load) begin
      r_pend_val <= bus.value;
      r_pend_dp  <= bus.dp_in;
      r_pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display    <= SEG_OFF;
      r_ctrl       <= CTRL_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame;
      if (r_cnt < GUARD_C) begin
        r_ctrl    <= CTRL_OFF;
        r_display <= SEG_OFF;
      end else begin
        // Blanked digits keep their enable so every slot has the same duty.
        r_ctrl    <= ~(4'b0001 << r_idx);
        r_display <= w_blank ? SEG_OFF : {~r_act_dp[r_idx], w_seg};
      end
    end
  end

  assign bus.display    = r_display;
  assign bus.ctrl       = r_ctrl;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the binary down counter. Time-multiplexes a 16-bit value, as four hex digits, onto a 4-digit common-anode 7-segment display.
- Drives the shared segment bus `display` and the per-digit enables `ctrl`.
- New values are double-buffered and applied only at frame boundaries, so a digit never shows a torn value.
- A guard interval between digit slots suppresses ghosting.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be at least 2.
- GUARD, 2: cycles at the start of each slot during which all digits are off; must be less than REFRESH_DIV.
- BLANK_LZ, 1: 1 = leading-zero blanking enabled; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  16  four hex nibbles; nibble i goes to digit i (digit 0 = rightmost).
- load  in  1  single-cycle strobe; captures `value` and `dp_in`.
- dp_in  in  4  decimal-point request per digit, active-high.
- display  out  8  {dp, g, f, e, d, c, b, a}, active-low.
- ctrl  out  4  digit enables, active-low; one-hot-low or all-high.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Registers: slot counter=0, digit index=0, active and pending value/dp registers=0, pending_valid=0.
  - Outputs: display=8'hFF, ctrl=4'hF, frame_tick=0.
- Slot counter: counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances 0→1→2→3→0.
- Frame boundary: the cycle in which the counter wraps while index==3.
  - frame_tick=1 on the following cycle. It is a registered output, so the pulse coincides with index==0, count==0.
- load behaviour:
  - load=1 writes `value`/`dp_in` into the pending registers and sets pending_valid.
  - A later load before the boundary overwrites pending; last write wins.
- At a frame boundary with pending_valid=1: active <= pending, pending_valid <= 0.
- load coincident with a frame boundary: the load data goes straight into active, and pending_valid is cleared.
- Outputs are registered and are a function of (index, count, active). They change on the edge after the counter/index update, i.e. one cycle of latency.
- Guard interval (count < GUARD): ctrl=4'hF, display=8'hFF.
- Otherwise: ctrl = ~(4'b0001 << index), and display = {~dp[index], font(active nibble[index])}.
- Font (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked (display=8'hFF) if nibbles i..3 are all zero and dp[i]=0. Its ctrl bit is still driven, for constant duty.
  - Example: value 16'h0000 shows only "0" on digit 0.
- Reset asserted mid-frame: everything returns immediately to the reset values.
  - After release, scanning restarts at digit 0 showing 0, since active is reset to 0.
- No combinational path from any input to any output.

Decomposition:
- Package seg7_pkg:
  - 16-entry hex font constant array.
  - SEG_OFF=8'hFF, CTRL_OFF=4'hF.
  - Digit-index width constant (2).
- Sub-module seg7_hex_decoder (combinational nibble → 7-bit active-low segments), reusable by other display blocks.
- The scan counter, double buffer and blanking stay in seg7_scan_driver.

Test Plan (REFRESH_DIV=4, GUARD=1, BLANK_LZ=1 unless stated):
- Reset release, no load → digit 0 slots show ctrl=4'hE, display=8'hC0. Other slots show ctrl 4'hD/4'hB/4'h7 with display=8'hFF. The first cycle of every slot shows ctrl=4'hF.
- load value=16'h1A3F, dp_in=0, mid-frame → no change until frame_tick.
  - Then digit0=8'h8E, digit1=8'hB0, digit2=8'h88, digit3=8'hF9.
  - Period = 16 cycles per frame.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed: every digit shows 8'hA4.
- load exactly on the frame-boundary cycle with 16'h0007 → the next frame shows digit0=8'hF8, digits1–3 blanked (8'hFF). dp_in=4'b0100 un-blanks digit 2, showing 8'h40.
- BLANK_LZ=0, value 16'h0000 → all four digits show 8'hC0.
- Assert rst_n low mid-slot (asynchronous, between edges) → display=8'hFF and ctrl=4'hF immediately, with no clock edge. After release, scanning resumes at digit 0 showing 8'hC0.
